// File: rtl/mult_pkg.sv
// Shared types and mode decoding for the sequential multiply/MAC block.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, ACC, DONE} state_t;

  localparam logic [1:0] MODE_UMUL = 2'b00;
  localparam logic [1:0] MODE_SMUL = 2'b01;
  localparam logic [1:0] MODE_UMAC = 2'b10;
  localparam logic [1:0] MODE_SMAC = 2'b11;

  function automatic logic is_signed(input logic [1:0] mode);
    return mode[0];
  endfunction

  function automatic logic is_mac(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: unsigned add-if-Q[0] or radix-2 Booth, followed by a right shift.
module mult_step #(
  parameter int N = 8
) (
  input  logic [N:0]   a_i,
  input  logic [N-1:0] q_i,
  input  logic         qm1_i,
  input  logic [N-1:0] m_i,
  input  logic         signed_i,
  output logic [N:0]   a_o,
  output logic [N-1:0] q_o,
  output logic         qm1_o
);

  logic [N:0] m_ext;
  logic [N:0] sum;

  always_comb begin
    m_ext = signed_i ? {m_i[N-1], m_i} : {1'b0, m_i};
    sum   = a_i;
    if (signed_i) begin
      case ({q_i[0], qm1_i})
        2'b01:   sum = a_i + m_ext;
        2'b10:   sum = a_i - m_ext;
        default: sum = a_i;
      endcase
    end else if (q_i[0]) begin
      sum = a_i + m_ext;
    end
    // Unsigned: sum[N] is the carry and shifts into A; signed: A's sign is replicated.
    a_o   = {signed_i & sum[N], sum[N:1]};
    q_o   = {sum[0], q_i[N-1:1]};
    qm1_o = q_i[0];
  end

endmodule

// File: rtl/seq_mac_multiplier.sv
// Sequential N-iteration multiplier with optional accumulate stage and sticky overflow.
module seq_mac_multiplier
  import mult_pkg::*;
#(
  parameter int N = 8,
  parameter int G = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 clear_acc,
  input  logic [N-1:0]         multiplicand,
  input  logic [N-1:0]         multiplier,
  output logic                 ready,
  output logic                 done,
  output logic [2*N-1:0]       product,
  output logic [2*N+G-1:0]     acc,
  output logic                 overflow
);

  localparam int ACC_W = 2*N + G;
  localparam int CW    = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N-1);

  state_t           state_q;
  logic [1:0]       mode_q;
  logic [N-1:0]     m_q, q_q;
  logic [N:0]       a_q;
  logic             qm1_q;
  logic [CW-1:0]    cnt_q;
  logic             ready_q, done_q;
  logic [2*N-1:0]   product_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic [N:0]       a_d;
  logic [N-1:0]     q_d;
  logic             qm1_d;

  mult_step #(.N(N)) u_step (
    .a_i     (a_q),
    .q_i     (q_q),
    .qm1_i   (qm1_q),
    .m_i     (m_q),
    .signed_i(is_signed(mode_q)),
    .a_o     (a_d),
    .q_o     (q_d),
    .qm1_o   (qm1_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= 2'b00;
      m_q       <= '0;
      q_q       <= '0;
      a_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            ready_q <= 1'b0;
            mode_q  <= mode;
            m_q     <= multiplicand;
            q_q     <= multiplier;
            a_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= CNT_LAST;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          a_q   <= a_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            product_q <= {a_d[N-1:0], q_d};
            if (is_mac(mode_q)) begin
              state_q <= ACC;
            end else begin
              state_q <= DONE;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
            end
          end
        end
        ACC: begin
          state_q <= DONE;
          ready_q <= 1'b1;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   acc_sum;
  logic             ovf_add;

  always_comb begin
    prod_ext = is_signed(mode_q) ? {{G{product_q[2*N-1]}}, product_q}
                                 : {{G{1'b0}}, product_q};
    acc_sum  = {1'b0, acc_q} + {1'b0, prod_ext};
    // Signed overflow: like-signed operands producing an opposite-signed sum.
    if (is_signed(mode_q))
      ovf_add = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
    else
      ovf_add = acc_sum[ACC_W];
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clear_acc) begin
      acc_d = (state_q == ACC) ? prod_ext : '0;
      ovf_d = 1'b0;
    end else if (state_q == ACC) begin
      acc_d = acc_sum[ACC_W-1:0];
      ovf_d = ovf_q | ovf_add;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign product  = product_q;
  assign acc      = acc_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_mac_multiplier.sv
// Directed and randomized checks of seq_mac_multiplier against an arithmetic reference model.
module tb_seq_mac_multiplier;
  import mult_pkg::*;

  localparam int N = 8;
  localparam int G = 4;
  localparam int ACC_W = 2*N + G;
  localparam longint ACC_MOD = 64'd1 << ACC_W;
  localparam longint ACC_HALF = 64'd1 << (ACC_W - 1);

  logic             clock;
  logic             reset;
  logic             start;
  logic [1:0]       mode;
  logic             clear_acc;
  logic [N-1:0]     multiplicand;
  logic [N-1:0]     multiplier;
  logic             ready;
  logic             done;
  logic [2*N-1:0]   product;
  logic [ACC_W-1:0] acc;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  longint macc = 0;
  bit     movf = 0;

  seq_mac_multiplier #(.N(N), .G(G)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .clear_acc   (clear_acc),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .ready       (ready),
    .done        (done),
    .product     (product),
    .acc         (acc),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues one operation and waits for its done pulse.
  task automatic do_op(input logic [1:0] md, input logic [7:0] m, input logic [7:0] q,
                       input int poke_at, input int clr_at);
    int cyc;
    int prod;
    logic [15:0] pe;
    longint p_val, sa, s;
    chk("ready_before_start", ready, 1);
    mode = md; multiplicand = m; multiplier = q; start = 1;
    @(posedge clock);
    cyc = 1;
    @(negedge clock);
    start = 0;
    mode = 2'($urandom);
    multiplicand = 8'($urandom);
    multiplier = 8'($urandom);
    while (done !== 1'b1 && cyc < 40) begin
      start = (cyc == poke_at);
      clear_acc = (cyc == clr_at);
      @(posedge clock);
      cyc++;
      @(negedge clock);
    end
    start = 0;
    clear_acc = 0;
    chk("done_latency", cyc, md[1] ? N + 2 : N + 1);

    if (md[0]) prod = int'($signed(m)) * int'($signed(q));
    else       prod = int'(m) * int'(q);
    pe = prod[15:0];
    chk("product", product, pe);

    if (md[1]) begin
      p_val = md[0] ? longint'(prod) : longint'(pe);
      if (clr_at == N + 1) begin
        macc = ((p_val % ACC_MOD) + ACC_MOD) % ACC_MOD;
        movf = 0;
      end else if (md[0]) begin
        sa = (macc >= ACC_HALF) ? macc - ACC_MOD : macc;
        s = sa + p_val;
        if (s < -ACC_HALF || s >= ACC_HALF) movf = 1;
        macc = ((s % ACC_MOD) + ACC_MOD) % ACC_MOD;
      end else begin
        s = macc + p_val;
        if (s >= ACC_MOD) movf = 1;
        macc = s % ACC_MOD;
      end
    end
    chk("acc", acc, 32'(macc));
    chk("overflow", overflow, movf);
    chk("ready_at_done", ready, 1);
  endtask

  task automatic do_clear();
    clear_acc = 1;
    @(posedge clock);
    @(negedge clock);
    clear_acc = 0;
    macc = 0;
    movf = 0;
    chk("acc_cleared", acc, 0);
    chk("ovf_cleared", overflow, 0);
  endtask

  initial begin
    bit saw_done;
    clock = 0; reset = 1; start = 0; mode = 0; clear_acc = 0;
    multiplicand = 0; multiplier = 0;

    #12;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    chk("rst_acc", acc, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clock);
    reset = 0;

    // Unsigned full-scale product, then the done pulse must last one cycle.
    do_op(MODE_UMUL, 8'd255, 8'd255, 0, 0);
    chk("umul_ff_const", product, 16'hFE01);
    @(posedge clock); @(negedge clock);
    chk("done_one_cycle", done, 0);

    // Signed corner cases.
    do_op(MODE_SMUL, 8'h80, 8'h80, 0, 0);
    chk("smul_m128sq", product, 16'h4000);
    do_op(MODE_SMUL, 8'h80, 8'h7F, 0, 0);
    chk("smul_m128x127", product, 16'hC080);
    do_op(MODE_SMUL, 8'h00, 8'hFF, 0, 0);
    do_op(MODE_SMUL, 8'hFF, 8'hFF, 0, 0);
    chk("smul_m1xm1", product, 16'h0001);

    // Back-to-back signed MAC.
    do_clear();
    do_op(MODE_SMAC, 8'hFB, 8'd7, 0, 0);
    do_op(MODE_SMAC, 8'd100, 8'd100, 0, 0);
    do_op(MODE_SMAC, 8'h80, 8'h80, 0, 0);
    chk("smac_sum_const", acc, 26349);

    // Unsigned MAC saturating the accumulator; overflow must stick.
    do_clear();
    for (int i = 0; i < 16; i++) do_op(MODE_UMAC, 8'd255, 8'd255, 0, 0);
    chk("umac16_const", acc, 1040400);
    chk("umac16_ovf", overflow, 0);
    do_op(MODE_UMAC, 8'd255, 8'd255, 0, 0);
    chk("umac17_const", acc, 56849);
    chk("umac17_ovf", overflow, 1);
    do_op(MODE_UMUL, 8'd3, 8'd3, 0, 0);
    do_op(MODE_SMAC, 8'd1, 8'd1, 0, 0);
    chk("ovf_sticky", overflow, 1);
    do_clear();

    // Start pulsed mid-RUN with junk operands is ignored.
    do_op(MODE_UMUL, 8'd13, 8'd11, 3, 0);
    chk("poke_ignored", product, 143);

    // Clear in the ACC cycle replaces the accumulator with the new product.
    do_clear();
    do_op(MODE_SMAC, 8'd20, 8'd25, 0, 0);
    chk("acc_500", acc, 500);
    do_op(MODE_SMAC, 8'hFB, 8'd7, 0, N + 1);
    chk("clr_in_acc_const", acc, 20'hFFFDD);

    // Asynchronous reset in the middle of RUN.
    @(posedge clock); @(negedge clock);
    mode = MODE_UMUL; multiplicand = 8'd77; multiplier = 8'd99; start = 1;
    @(posedge clock); @(negedge clock);
    start = 0;
    repeat (3) begin @(posedge clock); @(negedge clock); end
    reset = 1;
    #1;
    chk("midrun_rst_ready", ready, 1);
    chk("midrun_rst_done", done, 0);
    chk("midrun_rst_product", product, 0);
    chk("midrun_rst_acc", acc, 0);
    macc = 0; movf = 0;
    @(negedge clock);
    reset = 0;
    saw_done = 0;
    repeat (20) begin
      @(posedge clock); @(negedge clock);
      if (done === 1'b1) saw_done = 1;
    end
    chk("no_done_after_abort", saw_done, 0);

    // Randomized mix of modes and operands.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(7, 0) == 0) do_clear();
      do_op(2'($urandom), 8'($urandom), 8'($urandom), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
